// File: rtl/mode_ctrl_if.sv
// Button, edit and done inputs plus tick, per-client pulse, mode and alarm outputs of mode_ctrl.
// master is the sequencer side; slave is the board/client side.
interface mode_ctrl_if;
    logic       btn_c;
    logic       btn_l;
    logic       btn_d;
    logic       btn_r;
    logic       btn_u;
    logic [2:0] edit_i;
    logic       timer_done_i;
    logic       tick_o;
    logic [3:0] clock_btn_o;
    logic [3:0] sw_btn_o;
    logic [3:0] timer_btn_o;
    logic [1:0] mode_o;
    logic       alarm_o;

    modport master (
        input  btn_c, btn_l, btn_d, btn_r, btn_u, edit_i, timer_done_i,
        output tick_o, clock_btn_o, sw_btn_o, timer_btn_o, mode_o, alarm_o
    );

    modport slave (
        output btn_c, btn_l, btn_d, btn_r, btn_u, edit_i, timer_done_i,
        input  tick_o, clock_btn_o, sw_btn_o, timer_btn_o, mode_o, alarm_o
    );
endinterface

// File: rtl/mode_ctrl.sv
// Watch sequencer: tick divider, button edge arbitration, per-mode button routing and
// timed alarm on the timer's done edge.
module mode_ctrl #(
    parameter int unsigned CLK_HZ   = 100000000,
    parameter int unsigned TICK_HZ  = 1000,
    parameter int unsigned ALARM_MS = 3000
) (
    input logic        clk,
    input logic        rst,
    mode_ctrl_if.master bus
);
    localparam int unsigned Div    = CLK_HZ / TICK_HZ;
    localparam int unsigned DivW   = (Div > 1) ? $clog2(Div) : 1;
    localparam int unsigned AlarmW = $clog2(ALARM_MS + 1);
    localparam logic [DivW-1:0]   DivMax    = DivW'(Div - 1);
    localparam logic [AlarmW-1:0] AlarmInit = AlarmW'(ALARM_MS);

    typedef enum logic [1:0] {StNormal, StAlarm, StAck} state_e;

    state_e            state_q, state_d;
    logic [DivW-1:0]   div_q, div_d;
    logic              tick_q;
    logic [4:0]        lvl, prev_q, edges;
    logic              done_prev_q, done_rise, any_edge;
    logic [AlarmW-1:0] acnt_q, acnt_d;
    logic [1:0]        mode_q, mode_d;
    logic [3:0]        clk_btn_q, clk_btn_d, sw_btn_q, sw_btn_d, tmr_btn_q, tmr_btn_d;
    logic [3:0]        win_bits;
    logic              win_u, cur_edit;

    // Low four bits match the {R,D,L,C} client pulse order.
    assign lvl       = {bus.btn_u, bus.btn_r, bus.btn_d, bus.btn_l, bus.btn_c};
    assign edges     = lvl & ~prev_q;
    assign any_edge  = |edges;
    assign done_rise = bus.timer_done_i & ~done_prev_q;
    assign div_d     = (div_q == DivMax) ? '0 : div_q + DivW'(1);

    always_comb begin
        win_u    = 1'b0;
        win_bits = '0;
        if (edges[4])      win_u    = 1'b1;
        else if (edges[1]) win_bits = 4'b0010;
        else if (edges[3]) win_bits = 4'b1000;
        else if (edges[0]) win_bits = 4'b0001;
        else if (edges[2]) win_bits = 4'b0100;
    end

    always_comb begin
        cur_edit = 1'b0;
        case (mode_q)
            2'd0:    cur_edit = bus.edit_i[0];
            2'd1:    cur_edit = bus.edit_i[1];
            2'd2:    cur_edit = bus.edit_i[2];
            default: cur_edit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StNormal;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StNormal: if (done_rise) state_d = StAlarm;
            // Dismissal beats a coincident final tick.
            StAlarm: begin
                if (any_edge)                         state_d = StAck;
                else if (tick_q && acnt_q <= AlarmW'(1)) state_d = StNormal;
            end
            StAck:   if (lvl == '0) state_d = StNormal;
            default: state_d = StNormal;
        endcase
    end

    always_comb begin
        mode_d    = mode_q;
        acnt_d    = acnt_q;
        clk_btn_d = '0;
        sw_btn_d  = '0;
        tmr_btn_d = '0;
        unique case (state_q)
            StNormal: begin
                if (done_rise) begin
                    mode_d = 2'd2;
                    acnt_d = AlarmInit;
                end else if (win_u) begin
                    if (!cur_edit) mode_d = (mode_q >= 2'd2) ? 2'd0 : mode_q + 2'd1;
                end else begin
                    case (mode_q)
                        2'd0:    clk_btn_d = win_bits;
                        2'd1:    sw_btn_d  = win_bits;
                        2'd2:    tmr_btn_d = win_bits;
                        default: ;
                    endcase
                end
            end
            StAlarm: begin
                if (!any_edge && tick_q && acnt_q != '0) acnt_d = acnt_q - AlarmW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q       <= '0;
            tick_q      <= 1'b0;
            prev_q      <= '1;
            done_prev_q <= 1'b1;
            acnt_q      <= '0;
            mode_q      <= 2'd0;
            clk_btn_q   <= '0;
            sw_btn_q    <= '0;
            tmr_btn_q   <= '0;
        end else begin
            div_q       <= div_d;
            tick_q      <= (div_d == DivMax);
            prev_q      <= lvl;
            done_prev_q <= bus.timer_done_i;
            acnt_q      <= acnt_d;
            mode_q      <= mode_d;
            clk_btn_q   <= clk_btn_d;
            sw_btn_q    <= sw_btn_d;
            tmr_btn_q   <= tmr_btn_d;
        end
    end

    assign bus.tick_o      = tick_q;
    assign bus.clock_btn_o = clk_btn_q;
    assign bus.sw_btn_o    = sw_btn_q;
    assign bus.timer_btn_o = tmr_btn_q;
    assign bus.mode_o      = mode_q;
    assign bus.alarm_o     = (state_q == StAlarm);
endmodule

// File: tb/tb_mode_ctrl.sv
// Directed bench for mode_ctrl with DIV=10, ALARM_MS=3; client pulses are checked against a
// scoreboard of expected {clock,sw,timer} pulse words.
module tb_mode_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btns = '0;   // {U, R, D, L, C}
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc;
    logic [11:0] sb[$];

    mode_ctrl_if bus ();

    assign bus.btn_c = btns[0];
    assign bus.btn_l = btns[1];
    assign bus.btn_d = btns[2];
    assign bus.btn_r = btns[3];
    assign bus.btn_u = btns[4];

    mode_ctrl #(.CLK_HZ(10), .TICK_HZ(1), .ALARM_MS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive levels before the next rising edge, return just after it.
    task automatic cyc1(input logic [4:0] m);
        btns = m;
        @(negedge clk);
    endtask

    // Every nonzero client pulse word must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [11:0] obs, exp;
        obs = {bus.clock_btn_o, bus.sw_btn_o, bus.timer_btn_o};
        if (!rst && obs != '0) begin
            exp = (sb.size() == 0) ? 12'h000 : sb.pop_front();
            check("client_pulse", 32'(obs), 32'(exp));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ticks, e, t3, guard;
        bus.edit_i       = 3'b000;
        bus.timer_done_i = 1'b0;

        // Reset values
        @(negedge clk); @(negedge clk);
        check("rst_mode", 32'(bus.mode_o), 0);
        check("rst_tick", 32'(bus.tick_o), 0);
        check("rst_alarm", 32'(bus.alarm_o), 0);
        check("rst_pulses", 32'({bus.clock_btn_o, bus.sw_btn_o, bus.timer_btn_o}), 0);

        // Tick: high for one cycle, sampled by edges 10, 20, 30
        rst = 1'b0;
        ticks = 0;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            check($sformatf("tick_k%0d", k), 32'(bus.tick_o), 32'((k % 10) == 9));
            ticks += int'(bus.tick_o);
        end
        check("tick_count", 32'(ticks), 3);

        // Mode stepping
        cyc1(5'b10000); check("mode_step1", 32'(bus.mode_o), 1); cyc1(5'b0);
        cyc1(5'b10000); check("mode_step2", 32'(bus.mode_o), 2); cyc1(5'b0);
        cyc1(5'b10000); check("mode_step0", 32'(bus.mode_o), 0); cyc1(5'b0);
        cyc1(5'b10000); check("mode_back1", 32'(bus.mode_o), 1); cyc1(5'b0);
        sb.push_back({4'b0000, 4'b0001, 4'b0000});
        cyc1(5'b00001); cyc1(5'b0); cyc1(5'b0);

        // Edit lock on the timer, L beats D
        cyc1(5'b10000); check("mode_to2", 32'(bus.mode_o), 2); cyc1(5'b0);
        bus.edit_i = 3'b100;
        cyc1(5'b10000); check("edit_hold", 32'(bus.mode_o), 2); cyc1(5'b0);
        sb.push_back({4'b0000, 4'b0000, 4'b0010});
        cyc1(5'b00110); cyc1(5'b0); cyc1(5'b0);
        bus.edit_i = 3'b000;
        cyc1(5'b10000); check("mode_wrap0", 32'(bus.mode_o), 0); cyc1(5'b0);

        // Alarm timeout after the third consumed tick
        bus.timer_done_i = 1'b1;
        cyc1(5'b0);
        check("alarm_on", 32'(bus.alarm_o), 1);
        check("alarm_mode", 32'(bus.mode_o), 2);
        e  = cyc;
        t3 = (e / 10 + 1) * 10 + 20;
        guard = 0;
        while (cyc < t3 - 1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("alarm_wait_bound", 32'(cyc), 32'(t3 - 1));
        check("alarm_before_end", 32'(bus.alarm_o), 1);
        @(negedge clk);
        check("alarm_timeout", 32'(bus.alarm_o), 0);
        bus.timer_done_i = 1'b0;
        sb.push_back({4'b0000, 4'b0000, 4'b0001});
        cyc1(5'b00001); cyc1(5'b0); cyc1(5'b0);

        // Dismiss with held R; nothing forwarded until all buttons are low
        bus.timer_done_i = 1'b1;
        cyc1(5'b0);
        check("alarm2_on", 32'(bus.alarm_o), 1);
        cyc1(5'b01000);
        check("alarm_dismiss", 32'(bus.alarm_o), 0);
        cyc1(5'b01001); cyc1(5'b01000); cyc1(5'b0);
        sb.push_back({4'b0000, 4'b0000, 4'b0001});
        cyc1(5'b00001); cyc1(5'b0); cyc1(5'b0);

        // Reset mid-alarm with C held through it
        bus.timer_done_i = 1'b0;
        cyc1(5'b0);
        bus.timer_done_i = 1'b1;
        cyc1(5'b0);
        check("alarm3_on", 32'(bus.alarm_o), 1);
        btns = 5'b00001;
        rst  = 1'b1;
        #1;
        check("rst_alarm_async", 32'(bus.alarm_o), 0);
        check("rst_mode_async", 32'(bus.mode_o), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        cyc1(5'b00001); cyc1(5'b00001); cyc1(5'b00001);
        check("post_rst_mode", 32'(bus.mode_o), 0);
        check("post_rst_alarm", 32'(bus.alarm_o), 0);
        cyc1(5'b0);
        bus.timer_done_i = 1'b0;
        cyc1(5'b0); cyc1(5'b0);
        check("sb_drained", 32'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mode_ctrl.md
# mode_ctrl

Top-level sequencer for the watch datapaths: clock (mode 0), stopwatch (mode 1) and countdown timer (mode 2). It generates the shared millisecond tick enable and edge-detects the five board buttons. Button pulses go only to the client that owns the display, and the block selects which client's 36-bit BCD value is shown. When the timer's done flag rises, it runs a timed alarm that a button press can dismiss.

## Interface
- CLK_HZ, 100000000, system clock frequency
- TICK_HZ, 1000, tick_o rate; DIV = CLK_HZ/TICK_HZ, must be integer ≥ 2
- ALARM_MS, 3000, alarm duration in ticks, ≥ 1
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- btn_c, btn_l, btn_d, btn_r, btn_u  in  1 each  debounced, synchronized button levels
- edit_i  in  3  per-client edit flag; bit n = mode n's client is in edit mode
- timer_done_i  in  1  timer done level
- tick_o  out  1  one-cycle pulse every DIV cycles
- clock_btn_o, sw_btn_o, timer_btn_o  out  4 each  one-cycle pulses {R,D,L,C} to each client
- mode_o  out  2  active mode, 0..2; also the display mux select
- alarm_o  out  1  alarm active, drives buzzer/LED

## Operation
- Tick divider: counter 0..DIV-1; tick_o = 1 in the cycle the counter equals DIV-1, then the counter wraps to 0. The counter runs in all states. Width is $clog2(DIV).
- Edge detect: one prev register per button, reset to 1, so a button held through reset does not fire. edge = level & ~prev.
- Arbitration: at most one button event per cycle. Priority: U > L > R > C > D. Lower-priority edges in the same cycle are discarded, not queued.
- FSM states are NORMAL, ALARM and ACK.
- NORMAL:
  - U edge with edit_i[mode_o] = 0: mode_o advances 0→1→2→0. No client pulse is emitted.
  - U edge with edit_i[mode_o] = 1: ignored.
  - Any other winning edge: the matching bit is pulsed on the client selected by mode_o only. The other two clients' outputs stay 0.
  - Rising edge of timer_done_i: go to ALARM. The done_prev register resets to 1. On entry: alarm_o = 1, mode_o = 2, alarm counter = ALARM_MS. This takes precedence over any button edge in the same cycle, and that edge is discarded.
- ALARM:
  - All client pulses are suppressed.
  - Each tick_o decrements the alarm counter. The tick that brings it to 0 goes to NORMAL with alarm_o = 0.
  - Any button edge (including U) dismisses: alarm_o = 0, go to ACK. Dismissal wins over a simultaneous final tick.
- ACK: all client pulses are suppressed until all five buttons are low, then go to NORMAL. The button that dismissed the alarm is never forwarded.
- timer_done_i falling during ALARM has no effect. A new rising edge while in ALARM or ACK is ignored.
- mode_o is never 3. If it is ever 3, the next U edge (or alarm entry) yields 0 (or 2).

## Timing
- Reset values (asynchronous, immediate): mode_o = 0, tick_o = 0, all *_btn_o = 0, alarm_o = 0, state NORMAL, divider = 0, alarm counter = 0, all prev registers = 1.
- Reset asserted mid-alarm: alarm_o drops in the same instant it asserts.
- First tick_o after reset release: cycle DIV (counted from the first clock edge = cycle 1). Period is exactly DIV afterwards.
- Button latency: a level rising before edge k produces the *_btn_o pulse in the cycle after edge k. The pulse is exactly 1 cycle wide. A held button produces one pulse.
- The mode_o change is visible in the cycle after edge k. A button edge at edge k+1 is routed by the new mode.
- Alarm: alarm_o rises in the cycle after the done edge is sampled. Timeout lasts ALARM_MS ticks, so ALARM_MS×DIV cycles ±DIV depending on divider phase.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- Params CLK_HZ=10, TICK_HZ=1 (DIV=10), ALARM_MS=3. Release reset, run 35 cycles → tick_o pulses at cycles 10, 20, 30 only, each 1 cycle wide.
- mode_o=0, edit_i=0: pulse btn_u three times → mode_o 1, 2, 0. With mode_o=1, press btn_c → sw_btn_o=4'b0001 for 1 cycle; clock_btn_o and timer_btn_o stay 0.
- mode_o=2, edit_i=3'b100: press btn_u → mode_o stays 2. Press btn_l and btn_d simultaneously → timer_btn_o=4'b0010 once, and D is never delivered.
- mode_o=0, timer_done_i 0→1 → alarm_o=1 and mode_o=2 next cycle; no further input → alarm_o=0 after the 3rd tick; state NORMAL; no client pulses throughout.
- Alarm active, press and hold btn_r → alarm_o=0 next cycle; no timer_btn_o pulse; release btn_r, then press btn_c → timer_btn_o=4'b0001.
- Hold btn_c through reset, assert rst during ALARM → alarm_o=0 immediately; after release, no pulse from the held btn_c; mode_o=0.
